// File: rtl/trace_pkg.sv
// trace_pkg: shared commit trace record layout and helpers
package trace_pkg;
  localparam int SEQ_W = 16;
  localparam logic [6:0] MEMW_8  = 7'd8;
  localparam logic [6:0] MEMW_16 = 7'd16;
  localparam logic [6:0] MEMW_32 = 7'd32;
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      insn;
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [6:0]       width;
    logic             trap;
    logic [31:0]      cause;
  } trace_rec_t;
  localparam int REC_W = $bits(trace_rec_t);
  // Memory fields are meaningful only with an access; cause only with a trap.
  function automatic trace_rec_t make_rec(
    input logic [SEQ_W-1:0] seq, input logic [31:0] pc, input logic [31:0] insn,
    input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [6:0] width, input logic trap, input logic [31:0] cause);
    logic m;
    m = rd | wr;
    return '{seq: seq, pc: pc, insn: insn, rd: rd, wr: wr,
             addr: m ? addr : 32'h0, wdata: m ? wdata : 32'h0, width: m ? width : 7'h0,
             trap: trap, cause: trap ? cause : 32'h0};
  endfunction
endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: commit capture inputs and trace record stream
interface commit_trace_buffer_if;
  import trace_pkg::*;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_insn;
  logic        mem_rd_valid;
  logic        mem_wr_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  mem_width;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic        out_valid;
  logic        out_ready;
  trace_rec_t  out_rec;
  modport master (
    output commit_valid, commit_pc, commit_insn, mem_rd_valid, mem_wr_valid,
           mem_addr, mem_wdata, mem_width, trap_valid, trap_cause, out_ready,
    input  out_valid, out_rec
  );
  modport slave (
    input  commit_valid, commit_pc, commit_insn, mem_rd_valid, mem_wr_valid,
           mem_addr, mem_wdata, mem_width, trap_valid, trap_cause, out_ready,
    output out_valid, out_rec
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with separate occupancy count, no bypass
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [AW:0]      count_next
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop, flush;
  assign flush = reset | clear;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count_next = flush ? '0 : count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata = empty ? '0 : mem[rd_ptr];
  // Pointers wrap naturally; count disambiguates full from empty.
  always_ff @(posedge clock) begin
    wr_ptr <= flush ? '0 : wr_ptr + AW'(do_push);
    rd_ptr <= flush ? '0 : rd_ptr + AW'(do_pop);
    count  <= count_next;
  end
  // Storage needs no reset; stale entries are hidden by empty.
  always_ff @(posedge clock) begin
    if (do_push & ~flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures retired-instruction records and streams them to difftest
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SLACK = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  commit_trace_buffer_if.slave  bus,
  output logic                  stall_req,
  output logic [CW-1:0]         count,
  output logic                  overflow
);
  logic [SEQ_W-1:0] seq;
  logic push, full, empty;
  logic [CW-1:0] count_next;
  logic [REC_W-1:0] head;
  trace_rec_t rec;
  assign push = bus.commit_valid | bus.trap_valid;
  assign rec = make_rec(seq, bus.commit_pc, bus.commit_insn, bus.mem_rd_valid, bus.mem_wr_valid,
                        bus.mem_addr, bus.mem_wdata, bus.mem_width, bus.trap_valid, bus.trap_cause);
  assign bus.out_valid = ~empty;
  assign bus.out_rec = trace_rec_t'(head);
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clock(clock), .reset(reset), .clear(clear),
    .push(push), .pop(bus.out_ready), .wdata(rec), .rdata(head),
    .full(full), .empty(empty), .count(count), .count_next(count_next)
  );
  // Sequence numbers count push attempts, drops included; stall looks at next occupancy.
  always_ff @(posedge clock) begin
    if (reset | clear) begin
      seq       <= '0;
      overflow  <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      seq       <= seq + SEQ_W'(push);
      overflow  <= overflow | (push & full & ~bus.out_ready);
      stall_req <= count_next >= CW'(DEPTH - SLACK);
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed scoreboard bench for commit_trace_buffer
module tb_commit_trace_buffer;
  import trace_pkg::*;
  logic clock = 1'b0;
  logic reset, clear, stall_req, overflow;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  trace_rec_t q[$];
  logic [15:0] mseq;
  logic movf, mstall;
  commit_trace_buffer_if bus();
  commit_trace_buffer dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus.slave),
    .stall_req(stall_req), .count(count), .overflow(overflow)
  );
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic trace_rec_t expect_rec();
    trace_rec_t r;
    r = '0;
    r.seq = mseq;
    r.pc = bus.commit_pc;
    r.insn = bus.commit_insn;
    r.rd = bus.mem_rd_valid;
    r.wr = bus.mem_wr_valid;
    if (bus.mem_rd_valid || bus.mem_wr_valid) begin
      r.addr = bus.mem_addr;
      r.wdata = bus.mem_wdata;
      r.width = bus.mem_width;
    end
    r.trap = bus.trap_valid;
    if (bus.trap_valid) r.cause = bus.trap_cause;
    return r;
  endfunction

  task automatic tick();
    trace_rec_t r;
    if (reset || clear) begin
      q.delete();
      mseq = 0;
      movf = 0;
      mstall = 0;
    end else begin
      r = expect_rec();
      if (bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (bus.commit_valid || bus.trap_valid) begin
        if (q.size() < 16) q.push_back(r);
        else movf = 1;
        mseq++;
      end
      mstall = q.size() >= 14;
    end
    @(negedge clock);
    chk("count", count, q.size());
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_rec", bus.out_rec, q[0]);
    chk("stall_req", stall_req, mstall);
    chk("overflow", overflow, movf);
  endtask

  task automatic idle();
    bus.commit_valid = 0; bus.commit_pc = 0; bus.commit_insn = 0;
    bus.mem_rd_valid = 0; bus.mem_wr_valid = 0; bus.mem_addr = 0;
    bus.mem_wdata = 0; bus.mem_width = 0; bus.trap_valid = 0; bus.trap_cause = 0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] insn);
    idle();
    bus.commit_valid = 1; bus.commit_pc = pc; bus.commit_insn = insn;
  endtask

  initial begin
    idle();
    bus.out_ready = 0;
    clear = 0;
    reset = 1;
    tick();
    tick();
    chk("rst_rec", bus.out_rec, 0);
    chk("rst_count", count, 0);
    reset = 0;
    // three back-to-back commits drained immediately
    bus.out_ready = 1;
    commit(32'h0, 32'h13);
    tick();
    chk("seq0", bus.out_rec.seq, 0);
    commit(32'h4, 32'h13);
    tick();
    chk("seq1", bus.out_rec.seq, 1);
    commit(32'h8, 32'h13);
    tick();
    chk("seq2_pc", bus.out_rec.pc, 32'h8);
    idle();
    tick();
    chk("drained", count, 0);
    // store record
    bus.out_ready = 0;
    commit(32'h10, 32'h00B52023);
    bus.mem_wr_valid = 1; bus.mem_addr = 32'h100; bus.mem_wdata = 32'hDEADBEEF; bus.mem_width = MEMW_32;
    tick();
    chk("st_wr", bus.out_rec.wr, 1);
    chk("st_rd", bus.out_rec.rd, 0);
    chk("st_addr", bus.out_rec.addr, 32'h100);
    chk("st_wdata", bus.out_rec.wdata, 32'hDEADBEEF);
    chk("st_width", bus.out_rec.width, 32);
    // no access: mem fields zeroed; trap-only record keeps cause
    commit(32'h14, 32'h33);
    bus.mem_addr = 32'h55; bus.mem_wdata = 32'h77; bus.mem_width = MEMW_8; bus.trap_cause = 32'h9;
    tick();
    idle();
    bus.trap_valid = 1; bus.trap_cause = 32'h2;
    tick();
    chk("stable_hold", bus.out_rec.wr, 1);
    idle();
    bus.out_ready = 1;
    tick();
    chk("nomem_addr", bus.out_rec.addr, 0);
    chk("nomem_cause", bus.out_rec.cause, 0);
    tick();
    chk("trap_cause", bus.out_rec.cause, 32'h2);
    chk("trap_flag", bus.out_rec.trap, 1);
    tick();
    // backpressure: wrapper honours stall_req
    bus.out_ready = 0;
    for (int i = 0; i < 24; i++) begin
      if (stall_req) idle();
      else commit(32'h200 + 32'(i) * 4, 32'h13);
      tick();
    end
    chk("stall_count", count, 14);
    chk("stall_hi", stall_req, 1);
    chk("stall_ovf", overflow, 0);
    idle();
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) tick();
    chk("stall_lo", stall_req, 0);
    // overflow: 17 commits ignoring stall
    clear = 1;
    tick();
    clear = 0;
    bus.out_ready = 0;
    for (int i = 0; i < 17; i++) begin
      commit(32'h400 + 32'(i) * 4, 32'h13);
      tick();
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    idle();
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) tick();
    commit(32'h500, 32'h13);
    tick();
    chk("seq17", bus.out_rec.seq, 17);
    idle();
    tick();
    chk("ovf_sticky", overflow, 1);
    // full FIFO with simultaneous push and pop
    clear = 1;
    tick();
    clear = 0;
    chk("clr_ovf", overflow, 0);
    bus.out_ready = 0;
    for (int i = 0; i < 16; i++) begin
      commit(32'h600 + 32'(i) * 4, 32'h13);
      tick();
    end
    bus.out_ready = 1;
    commit(32'hF00, 32'h13);
    tick();
    chk("fpp_count", count, 16);
    chk("fpp_ovf", overflow, 0);
    idle();
    for (int i = 0; i < 15; i++) tick();
    chk("fpp_last", bus.out_rec.pc, 32'hF00);
    tick();
    // sequence wrap
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 65535; i++) begin
      commit(32'(i) * 4, 32'h13);
      tick();
    end
    commit(32'hA00, 32'h13);
    tick();
    chk("seq_ffff", bus.out_rec.seq, 16'hFFFF);
    commit(32'hA04, 32'h13);
    tick();
    chk("seq_wrap", bus.out_rec.seq, 0);
    // clear mid-stream, with a coincident push discarded
    bus.out_ready = 0;
    commit(32'hB00, 32'h13);
    tick();
    tick();
    clear = 1;
    tick();
    chk("clr_valid", bus.out_valid, 0);
    chk("clr_count", count, 0);
    clear = 0;
    idle();
    tick();
    chk("clr_empty", count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
